playlist_ctrl: RTL and testbench
================================

// Module: playlist_ctrl
// PURPOSE
//  Parametrised master control unit for the note player; successor to the 4-song play/pause MCU.
//  Tracks the current song index over NUM_SONGS entries and handles play/pause, next and previous.
//  Applies a repeat mode on song completion and drives a multi-cycle reset pulse to the song reader
//  and note player on every song switch. Sits between the one-pulsed buttons and the song_reader.
// PARAMETERS
//  NUM_SONGS     4  number of songs in ROM; legal range 2..256
//  SONG_W        2  song index width; must equal $clog2(NUM_SONGS)
//  SWITCH_CYCLES 2  cycles reset_player stays high per switch; legal range 1..15
// PORTS
//  clk           in   1       system clock
//  reset         in   1       reset, synchronous, active-high
//  play_button   in   1       one-cycle pulse: toggle play/pause
//  next_button   in   1       one-cycle pulse: advance to next song
//  prev_button   in   1       one-cycle pulse: go to previous song
//  song_done     in   1       one-cycle pulse from song_reader: current song finished
//  repeat_mode   in   2       00 STOP_AT_END, 01 LOOP_ALL, 10 REPEAT_ONE, 11 treated as LOOP_ALL
//  play          out  1       high while in PLAYING
//  reset_player  out  1       high while in SWITCH
//  song          out  SONG_W  current song index, registered
//  busy          out  1       high while in SWITCH; buttons are ignored
//  playlist_end  out  1       one-cycle pulse when STOP_AT_END wraps back to song 0
// BEHAVIOUR
//  - All outputs are registered. Inputs sampled on edge N take effect on outputs at edge N+1.
//  - Reset values: state=PAUSED, song=0, play=0, reset_player=0, busy=0, playlist_end=0.
//  - Reset takes priority over every other input, including mid-SWITCH; the switch counter clears.
//  - Input priority when events coincide in PAUSED/PLAYING: next > prev > play > song_done.
//  - States: PAUSED, PLAYING, SWITCH. The resume flag (1 bit) holds the state SWITCH exits to.
//  - PAUSED:  play -> PLAYING.
//             next/prev -> SWITCH, resume=PAUSED.
//             song_done is ignored.
//  - PLAYING: play -> PAUSED.
//             next/prev -> SWITCH, resume=PLAYING.
//             song_done -> SWITCH, with song and resume set by repeat_mode (below).
//  - SWITCH:  a counter runs 0..SWITCH_CYCLES-1, then the block enters resume.
//             All buttons and song_done are dropped, not queued.
//  - next: song = (song==NUM_SONGS-1) ? 0 : song+1.
//    prev: song = (song==0) ? NUM_SONGS-1 : song-1.
//  - song updates on the same edge the block enters SWITCH.
//  - song_done in LOOP_ALL: next-song rule, resume=PLAYING.
//  - song_done in REPEAT_ONE: song unchanged, resume=PLAYING.
//  - song_done in STOP_AT_END:
//      if song != NUM_SONGS-1: next-song rule, resume=PLAYING.
//      else: song=0, resume=PAUSED, playlist_end pulses on the edge entering SWITCH.
//  - repeat_mode is sampled only on the song_done cycle.
// CONFIGURATION
//  PLAYLIST_SHUFFLE_EN defined:
//  - Adds input shuffle (1 bit) and a free-running 8-bit LFSR, x^8+x^6+x^5+x^4+1, seed 8'h01 on reset.
//  - When shuffle=1, next and LOOP_ALL song_done use cand = lfsr[SONG_W-1:0].
//  - If cand >= NUM_SONGS, cand -= NUM_SONGS. If cand == song, cand = next-song rule.
//  - prev, REPEAT_ONE and STOP_AT_END are unaffected by shuffle.
//  PLAYLIST_SHUFFLE_EN undefined: no shuffle port, no LFSR; order is strictly sequential.
// TESTING
//  - reset high 1 cycle -> song=0, play=0, reset_player=0, busy=0, playlist_end=0.
//  - PAUSED, song=3, NUM_SONGS=4, pulse next -> song=0; reset_player high exactly 2 cycles;
//    then PAUSED with play=0.
//  - PLAYING song=0, pulse prev -> song=3, busy high 2 cycles, then play=1.
//    A play pulse during busy is ignored.
//  - PLAYING, repeat_mode=00, song=3, song_done -> song=0, playlist_end high 1 cycle,
//    final play=0. Same with repeat_mode=10 -> song=3, play=1.
//  - next and play pulsed on the same cycle while PAUSED at song 1 -> song=2, remains PAUSED.
//  - Shuffle=1 (macro on), 64 next pulses -> song always < NUM_SONGS,
//    never equal to the previous song.

Source files
------------

// File: rtl/playlist_ctrl.sv
// rtl/playlist_ctrl.sv - note player master control: song index, play/pause, next/prev, repeat modes.
// Optional shuffle order is built only when PLAYLIST_SHUFFLE_EN is defined.
module playlist_ctrl #(
  parameter int NUM_SONGS     = 4,
  parameter int SONG_W        = 2,
  parameter int SWITCH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              song_done,
  input  logic [1:0]        repeat_mode,
`ifdef PLAYLIST_SHUFFLE_EN
  input  logic              shuffle,
`endif
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic              busy,
  output logic              playlist_end
);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    SWITCH  = 2'd2
  } state_t;

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [3:0]        CNT_LAST  = 4'(SWITCH_CYCLES - 1);

  state_t            state_q;
  logic              resume_q;   // 1: SWITCH exits to PLAYING, 0: to PAUSED
  logic [3:0]        cnt_q;
  logic [SONG_W-1:0] song_q;
  logic              play_q;
  logic              reset_player_q;
  logic              busy_q;
  logic              playlist_end_q;

  logic [SONG_W-1:0] next_song;
  logic [SONG_W-1:0] prev_song;
  logic [SONG_W-1:0] advance_song;

  logic              sw_req_d;
  logic [SONG_W-1:0] sw_song_d;
  logic              sw_resume_d;
  logic              sw_end_d;
  logic              toggle_d;

  assign next_song = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
  assign prev_song = (song_q == '0) ? LAST_SONG : song_q - SONG_W'(1);

`ifdef PLAYLIST_SHUFFLE_EN
  logic [7:0]        lfsr_q;
  logic [SONG_W-1:0] cand_raw;
  logic [SONG_W-1:0] cand_wrap;
  logic [SONG_W-1:0] cand;

  // x^8+x^6+x^5+x^4+1, runs every cycle regardless of state
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign cand_raw  = lfsr_q[SONG_W-1:0];
  assign cand_wrap = ({1'b0, cand_raw} >= (SONG_W+1)'(NUM_SONGS)) ?
                     cand_raw - SONG_W'(NUM_SONGS) : cand_raw;
  assign cand      = (cand_wrap == song_q) ? next_song : cand_wrap;
  assign advance_song = shuffle ? cand : next_song;
`else
  assign advance_song = next_song;
`endif

  // Decode the single winning event for this cycle: next > prev > play > song_done.
  always_comb begin
    sw_req_d    = 1'b0;
    sw_song_d   = song_q;
    sw_resume_d = 1'b0;
    sw_end_d    = 1'b0;
    toggle_d    = 1'b0;
    if (state_q != SWITCH) begin
      if (next_button) begin
        sw_req_d    = 1'b1;
        sw_song_d   = advance_song;
        sw_resume_d = (state_q == PLAYING);
      end else if (prev_button) begin
        sw_req_d    = 1'b1;
        sw_song_d   = prev_song;
        sw_resume_d = (state_q == PLAYING);
      end else if (play_button) begin
        toggle_d = 1'b1;
      end else if (song_done && (state_q == PLAYING)) begin
        sw_req_d    = 1'b1;
        sw_resume_d = 1'b1;
        case (repeat_mode)
          2'b10: sw_song_d = song_q;
          2'b00: begin
            if (song_q == LAST_SONG) begin
              sw_song_d   = '0;
              sw_resume_d = 1'b0;
              sw_end_d    = 1'b1;
            end else begin
              sw_song_d = next_song;
            end
          end
          default: sw_song_d = advance_song;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PAUSED;
      resume_q       <= 1'b0;
      cnt_q          <= '0;
      song_q         <= '0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
      busy_q         <= 1'b0;
      playlist_end_q <= 1'b0;
    end else begin
      playlist_end_q <= 1'b0;
      case (state_q)
        SWITCH: begin
          if (cnt_q == CNT_LAST) begin
            state_q        <= resume_q ? PLAYING : PAUSED;
            play_q         <= resume_q;
            reset_player_q <= 1'b0;
            busy_q         <= 1'b0;
            cnt_q          <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          if (sw_req_d) begin
            state_q        <= SWITCH;
            song_q         <= sw_song_d;
            resume_q       <= sw_resume_d;
            cnt_q          <= '0;
            play_q         <= 1'b0;
            reset_player_q <= 1'b1;
            busy_q         <= 1'b1;
            playlist_end_q <= sw_end_d;
          end else if (toggle_d) begin
            state_q <= (state_q == PLAYING) ? PAUSED : PLAYING;
            play_q  <= (state_q != PLAYING);
          end
        end
      endcase
    end
  end

  assign play         = play_q;
  assign reset_player = reset_player_q;
  assign song         = song_q;
  assign busy         = busy_q;
  assign playlist_end = playlist_end_q;

endmodule

// File: tb/tb_playlist_ctrl.sv
// tb/tb_playlist_ctrl.sv - scoreboard bench for playlist_ctrl with directed vectors.
module tb_playlist_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_button = 1'b0;
  logic       next_button = 1'b0;
  logic       prev_button = 1'b0;
  logic       song_done = 1'b0;
  logic [1:0] repeat_mode = 2'b00;
`ifdef PLAYLIST_SHUFFLE_EN
  logic       shuffle = 1'b0;
`endif
  logic       play;
  logic       reset_player;
  logic [1:0] song;
  logic       busy;
  logic       playlist_end;

  int vectors = 0;
  int miscompares = 0;
  int vec_id = 0;

  logic [5:0] exp_q[$];
  int         id_q[$];

  always #5 clk = ~clk;

  playlist_ctrl #(.NUM_SONGS(4), .SONG_W(2), .SWITCH_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .play_button(play_button),
    .next_button(next_button),
    .prev_button(prev_button),
    .song_done(song_done),
    .repeat_mode(repeat_mode),
`ifdef PLAYLIST_SHUFFLE_EN
    .shuffle(shuffle),
`endif
    .play(play),
    .reset_player(reset_player),
    .song(song),
    .busy(busy),
    .playlist_end(playlist_end)
  );

  // Inputs: rst, play, next, prev, done, mode. Expected after the next edge:
  // {play, reset_player, song, busy, playlist_end}.
  task automatic step(input logic r, input logic pb, input logic nb, input logic vb,
                      input logic sd, input logic [1:0] rm,
                      input logic e_play, input logic e_rp, input logic [1:0] e_song,
                      input logic e_busy, input logic e_end);
    @(negedge clk);
    reset       = r;
    play_button = pb;
    next_button = nb;
    prev_button = vb;
    song_done   = sd;
    repeat_mode = rm;
    exp_q.push_back({e_play, e_rp, e_song, e_busy, e_end});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic idle(input logic e_play, input logic e_rp, input logic [1:0] e_song,
                      input logic e_busy);
    step(0, 0, 0, 0, 0, 2'b00, e_play, e_rp, e_song, e_busy, 0);
  endtask

  // Monitor: every edge that has a pending expectation is checked 1 time unit later.
  initial begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    int         id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        id    = id_q.pop_front();
        act_v = {play, reset_player, song, busy, playlist_end};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL vec%0d {play,rp,song,busy,end} got %b required %b", id, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    // reset and idle; song_done in PAUSED ignored
    step(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0);
    idle(0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 1, 2'b01, 0, 0, 2'd0, 0, 0);
    // prev from 0 while PAUSED -> 3, back to PAUSED
    step(0, 0, 0, 1, 0, 2'b00, 0, 1, 2'd3, 1, 0);
    idle(0, 1, 2'd3, 1);
    idle(0, 0, 2'd3, 0);
    // next from 3 wraps to 0, reset_player exactly 2 cycles
    step(0, 0, 1, 0, 0, 2'b00, 0, 1, 2'd0, 1, 0);
    idle(0, 1, 2'd0, 1);
    idle(0, 0, 2'd0, 0);
    // play, then prev while PLAYING; play during busy ignored
    step(0, 1, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 0);
    step(0, 0, 0, 1, 0, 2'b00, 0, 1, 2'd3, 1, 0);
    step(0, 1, 0, 0, 0, 2'b00, 0, 1, 2'd3, 1, 0);
    idle(1, 0, 2'd3, 0);
    idle(1, 0, 2'd3, 0);
    // STOP_AT_END at last song -> 0, playlist_end pulse, PAUSED
    step(0, 0, 0, 0, 1, 2'b00, 0, 1, 2'd0, 1, 1);
    idle(0, 1, 2'd0, 1);
    idle(0, 0, 2'd0, 0);
    // back to PLAYING at 3, REPEAT_ONE keeps 3 and resumes playing
    step(0, 0, 0, 1, 0, 2'b00, 0, 1, 2'd3, 1, 0);
    idle(0, 1, 2'd3, 1);
    idle(0, 0, 2'd3, 0);
    step(0, 1, 0, 0, 0, 2'b00, 1, 0, 2'd3, 0, 0);
    step(0, 0, 0, 0, 1, 2'b10, 0, 1, 2'd3, 1, 0);
    idle(0, 1, 2'd3, 1);
    idle(1, 0, 2'd3, 0);
    // LOOP_ALL wraps 3 -> 0; mode 11 behaves as LOOP_ALL 0 -> 1
    step(0, 0, 0, 0, 1, 2'b01, 0, 1, 2'd0, 1, 0);
    idle(0, 1, 2'd0, 1);
    idle(1, 0, 2'd0, 0);
    step(0, 0, 0, 0, 1, 2'b11, 0, 1, 2'd1, 1, 0);
    idle(0, 1, 2'd1, 1);
    idle(1, 0, 2'd1, 0);
    // STOP_AT_END on a non-last song just advances and keeps playing
    step(0, 0, 0, 0, 1, 2'b00, 0, 1, 2'd2, 1, 0);
    idle(0, 1, 2'd2, 1);
    idle(1, 0, 2'd2, 0);
    // pause, go to 1, then next+play together: next wins, stays PAUSED
    step(0, 1, 0, 0, 0, 2'b00, 0, 0, 2'd2, 0, 0);
    step(0, 0, 0, 1, 0, 2'b00, 0, 1, 2'd1, 1, 0);
    idle(0, 1, 2'd1, 1);
    idle(0, 0, 2'd1, 0);
    step(0, 1, 1, 0, 0, 2'b00, 0, 1, 2'd2, 1, 0);
    idle(0, 1, 2'd2, 1);
    idle(0, 0, 2'd2, 0);
    // next+prev together: next wins
    step(0, 0, 1, 1, 0, 2'b00, 0, 1, 2'd3, 1, 0);
    idle(0, 1, 2'd3, 1);
    idle(0, 0, 2'd3, 0);
    // reset mid-SWITCH, then a clean switch proves the counter restarted
    step(0, 1, 0, 0, 0, 2'b00, 1, 0, 2'd3, 0, 0);
    step(0, 0, 1, 0, 0, 2'b00, 0, 1, 2'd0, 1, 0);
    step(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0);
    idle(0, 0, 2'd0, 0);
    step(0, 0, 1, 0, 0, 2'b00, 0, 1, 2'd1, 1, 0);
    idle(0, 1, 2'd1, 1);
    idle(0, 0, 2'd1, 0);
    // song_done during SWITCH is dropped
    step(0, 1, 0, 0, 0, 2'b00, 1, 0, 2'd1, 0, 0);
    step(0, 0, 1, 0, 0, 2'b00, 0, 1, 2'd2, 1, 0);
    step(0, 0, 0, 0, 1, 2'b01, 0, 1, 2'd2, 1, 0);
    idle(1, 0, 2'd2, 0);
    idle(1, 0, 2'd2, 0);

    begin
      int budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() != 0) begin
        miscompares++;
        vectors++;
        $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
    end

`ifdef PLAYLIST_SHUFFLE_EN
    begin
      logic [1:0] prev_s;
      @(negedge clk);
      shuffle = 1'b1;
      for (int i = 0; i < 64; i++) begin
        prev_s = song;
        next_button = 1'b1;
        @(negedge clk);
        next_button = 1'b0;
        vectors++;
        if (song == prev_s || !busy) begin
          miscompares++;
          $display("FAIL shuffle%0d song %0d busy %b required !=%0d busy 1", i, song, busy, prev_s);
        end
        @(negedge clk);
        @(negedge clk);
      end
      shuffle = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
